dvv_ap_bcast: RTL
=================

// Module: dvv_ap_bcast
// PURPOSE
//  Synthesizable hardware analysis-port broadcaster: one producer stream fans out to CH_N
//  subscriber channels, each with its own buffer FIFO. Per-channel subscribe mask.
//  MODE selects blocking delivery (producer stalls until all subscribers have space) or
//  non-blocking delivery (full subscribers miss the item and count a drop).
//  Sits between a monitor-side stream source and independent consumers
//  (scoreboard, coverage, trace logic).
// PARAMETERS
//  DW     8   data width of one item, bits
//  CH_N   4   number of subscriber channels, 1..16
//  DEPTH  4   per-channel FIFO depth, power of two, >=2
//  MODE   0   0 = non-blocking (drop on full), 1 = blocking (stall on full)
//  CW     8   width of per-channel saturating drop counter
// PORTS
//  clk       in   1              clock, all logic on rising edge
//  rst       in   1              synchronous reset, active-high
//  sub_mask  in   CH_N           bit i=1: channel i subscribed; sampled on accept cycle
//  in_valid  in   1              producer item valid
//  in_ready  out  1              producer item accepted when in_valid&in_ready
//  in_data   in   DW             producer item
//  out_valid out  CH_N           channel i FIFO non-empty
//  out_ready in   CH_N           channel i consumer pops when out_valid[i]&out_ready[i]
//  out_data  out  CH_N*DW        channel i head item at [i*DW +: DW]
//  full      out  CH_N           channel i FIFO holds DEPTH items
//  drop_cnt  out  CH_N*CW        channel i dropped-item count at [i*CW +: CW]
//  drop_clr  in   1              clears all drop counters
// BEHAVIOUR
//  - Reset (rst=1 at edge): all FIFOs empty, pointers 0, count 0; next cycle out_valid=0,
//    full=0, drop_cnt=0. Reset mid-transfer discards all buffered items, no handshake completes.
//  - in_ready is combinational from registered state only, with no path from out_ready:
//    MODE=1: in_ready = ~|(sub_mask & full); MODE=0: in_ready = 1.
//  - Accept = in_valid & in_ready. On accept, every channel i with sub_mask[i]=1 and
//    full[i]=0 writes in_data. MODE=0: subscribed and full channels increment drop_cnt[i].
//  - sub_mask == 0: the item is accepted and discarded, with no write and no drop count.
//  - FIFO per channel: mem[DEPTH], wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH;
//    count 0..DEPTH. out_valid = (count != 0). out_data = mem[rd_ptr] (first-word fall-through).
//  - Latency: an item accepted at edge T appears on out_valid/out_data after edge T (1 cycle).
//  - Full determination uses registered count only. A pop in the same cycle does NOT free space
//    for a write to a full FIFO. A simultaneous push and pop on a non-full, non-empty FIFO
//    leaves count unchanged.
//  - Pop on an empty FIFO (out_ready with out_valid=0) is ignored; pointers do not move.
//  - Ordering: each channel delivers its items in accept order, with no duplication.
//  - drop_cnt saturates at 2^CW-1. drop_clr takes priority over a same-cycle increment
//    (result 0).
//  - Channels are independent: a stalled consumer on channel i never affects channel j in
//    MODE=0. In MODE=1 it stalls the producer only while i is subscribed.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, full=0, drop_cnt=0,
//    no writes occur.
//  2 Broadcast: mask=4'b1111, push 0x11,0x22, all out_ready=1 -> every channel emits
//    0x11 then 0x22, each 1 cycle after accept.
//  3 Mask: mask=4'b0101, push 0xA5 -> only ch0 and ch2 emit 0xA5. Push with mask=0
//    -> in_ready=1, no output, no drops.
//  4 MODE=0 drop: ch1 out_ready=0, push 6 items 0x01..0x06 -> ch1 full after 4 and holds
//    0x01..0x04, drop_cnt[1]=2, other channels deliver all 6.
//  5 MODE=1 stall: ch3 out_ready=0, push 5 items -> in_ready=0 after the 4th accept.
//    Release ch3 for one pop -> in_ready=1 the next cycle, item 5 accepted.
//    Release ch3 while ch3 is unsubscribed -> no stall.
//  6 Saturation/clear: CW=2, force 5 drops on ch0 -> drop_cnt[0]=3. drop_clr with a
//    simultaneous drop -> 0.

Source files
------------

// File: rtl/dvv_ap_bcast.sv
// dvv_ap_bcast: broadcasts one producer stream into per-channel FIFOs with subscribe mask and drop counters
module dvv_ap_bcast #(
  parameter int DW    = 8,
  parameter int CH_N  = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_N-1:0]      sub_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic [CH_N-1:0]      out_valid,
  input  logic [CH_N-1:0]      out_ready,
  output logic [CH_N*DW-1:0]   out_data,
  output logic [CH_N-1:0]      full,
  output logic [CH_N*CW-1:0]   drop_cnt,
  input  logic                 drop_clr
);
  localparam int AW = $clog2(DEPTH);
  logic acc;
  assign in_ready = (MODE != 0) ? ~|(sub_mask & full) : 1'b1;
  assign acc = in_valid & in_ready;
  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [CW-1:0] drops;
    logic          push, pop, drop;
    assign push = acc & sub_mask[i] & ~full[i];
    assign pop  = out_valid[i] & out_ready[i];
    assign drop = (MODE == 0) & acc & sub_mask[i] & full[i] & ~&drops;
    assign full[i] = cnt == (AW+1)'(DEPTH);
    assign out_valid[i] = cnt != '0;
    assign out_data[i*DW +: DW] = mem[rd_ptr];
    assign drop_cnt[i*CW +: CW] = drops;
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        drops  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        drops <= drop_clr ? '0 : drops + CW'(drop);
      end
    end
  end
endmodule
